melody_player: RTL and testbench
================================

MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 Parameter TICK_DIV, default 1_562_500, CLK25M cycles per tempo tick (1/16 s).
REQ-002 Parameter GAP_CYC, default 250_000, silent cycles between consecutive notes (10 ms).
REQ-003 Port CLK25M  input  1  sole clock, 25 MHz.
REQ-004 Port RSTN  input  1  reset, asynchronous, active-low.
REQ-005 Port EN  input  1  sound enable (switch level); low forces silence and idle.
REQ-006 Port START  input  1  level-sampled request to begin playback from note 0.
REQ-007 Port STOP  input  1  level-sampled request to abort playback.
REQ-008 Port LOOP  input  1  when high, restart at note 0 after end-of-song marker.
REQ-009 Port SPEAKER0  output  1  square-wave tone, registered.
REQ-010 Port SPEAKER1  output  1  complement of SPEAKER0 while sounding, else 0; registered.
REQ-011 Port BUSY  output  1  high in every state except IDLE.
REQ-012 Port NOTE_IDX  output  6  current song ROM address.

Function
REQ-013 Song ROM: 64 entries x 8 bits, {pitch[4:0], len[2:0]}; pitch 0 = rest, 1..24 = C4..B5, 31 = end marker; note lasts len+1 ticks.
REQ-014 Pitch table: 16-bit half-period count = round(25e6 / (2*f)); example A4 (pitch 10) = 28409.
REQ-015 FSM states IDLE, LOAD, PLAY, GAP; reset state IDLE.
REQ-016 IDLE: speakers 0; START=1 and EN=1 and STOP=0 -> LOAD next cycle with NOTE_IDX=0.
REQ-017 LOAD: one cycle for synchronous ROM read; then pitch 31 -> (LOOP ? LOAD with NOTE_IDX=0 : IDLE); otherwise -> PLAY, tick counter and tone counter cleared, duration = len+1.
REQ-018 PLAY: tone counter runs 0..half-1; at half-1 SPEAKER0 toggles and counter wraps to 0; first toggle occurs half cycles after PLAY entry; SPEAKER0 starts at 0 on entry.
REQ-019 PLAY with rest pitch: both speakers held 0 for the full duration.
REQ-020 Tick counter runs 0..TICK_DIV-1; each wrap decrements duration; duration reaching 0 -> GAP.
REQ-021 GAP: speakers 0 for GAP_CYC cycles; then NOTE_IDX increments (63 wraps to 0) -> LOAD.
REQ-022 STOP=1 or EN=0 in any non-IDLE state -> IDLE on next edge, speakers 0, NOTE_IDX=0.
REQ-023 START while BUSY is ignored; START and STOP together: STOP wins.
REQ-024 Note-to-note period = 1 (LOAD) + (len+1)*TICK_DIV + GAP_CYC + transitions, exactly as per REQ-017..021, no extra cycles.

Reset
REQ-025 RSTN low asynchronously forces IDLE, SPEAKER0=0, SPEAKER1=0, BUSY=0, NOTE_IDX=0, all counters 0.
REQ-026 Reset asserted mid-note takes effect immediately; after release the block waits for a new START.

Structure
REQ-027 Shared package sound_pkg holds pitch codes, PITCH_END=31, PITCH_REST=0, field widths, the half-period table, and state encodings.
REQ-028 Sub-module melody_rom (64x8 synchronous ROM, 1-cycle read latency) holds song data; pitch table is combinational in melody_player.
REQ-029 Intended to be instantiated in the top level alongside the existing tone block, sharing CLK25M and SW[0] as EN.

Verification (TICK_DIV=16, GAP_CYC=4, test ROM)
REQ-030 Reset during PLAY (ROM[0]={10,0}) -> speakers 0, BUSY 0, NOTE_IDX 0 within the same cycle as RSTN low.
REQ-031 ROM[0]={10,1}, ROM[1]={31,0}, LOOP=0, START pulse -> SPEAKER0 toggles every 28409 cycles for 32 cycles... (use test pitch half=3: toggles every 3 cycles), PLAY lasts 32 cycles, GAP 4, BUSY falls after end marker.
REQ-032 ROM[0]={0,0}, ROM[1]={31,0}, LOOP=1 -> 16 silent cycles, 4 gap, restart at NOTE_IDX=0 repeatedly, BUSY stays 1.
REQ-033 START and STOP both high in IDLE -> stays IDLE; STOP high during GAP -> IDLE next edge, NOTE_IDX=0.
REQ-034 EN dropped mid-note -> speakers 0 next edge; START while BUSY -> NOTE_IDX unaffected.
REQ-035 64 non-end entries, LOOP=0 -> NOTE_IDX wraps 63->0 and playback continues.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared sound definitions: pitch codes, field widths,
// half-period table, melody FSM state encoding.
package sound_pkg;

    localparam int PITCH_W   = 5;
    localparam int LEN_W     = 3;
    localparam int IDX_W     = 6;
    localparam int HALF_W    = 16;
    localparam int ROM_DEPTH = 64;

    localparam logic [PITCH_W-1:0] PITCH_REST = 5'd0;
    localparam logic [PITCH_W-1:0] PITCH_LAST = 5'd24;
    localparam logic [PITCH_W-1:0] PITCH_END  = 5'd31;

    localparam logic [PITCH_W-1:0] P_C4 = 5'd1;
    localparam logic [PITCH_W-1:0] P_D4 = 5'd3;
    localparam logic [PITCH_W-1:0] P_E4 = 5'd5;
    localparam logic [PITCH_W-1:0] P_F4 = 5'd6;
    localparam logic [PITCH_W-1:0] P_G4 = 5'd8;
    localparam logic [PITCH_W-1:0] P_A4 = 5'd10;
    localparam logic [PITCH_W-1:0] P_B4 = 5'd12;
    localparam logic [PITCH_W-1:0] P_C5 = 5'd13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP
    } state_t;

    // round(25e6 / (2*f)), equal temperament from C4
    function automatic logic [HALF_W-1:0] half_period(
        input logic [PITCH_W-1:0] p
    );
        case (p)
            5'd1:    half_period = 16'd47778;
            5'd2:    half_period = 16'd45097;
            5'd3:    half_period = 16'd42565;
            5'd4:    half_period = 16'd40176;
            5'd5:    half_period = 16'd37922;
            5'd6:    half_period = 16'd35793;
            5'd7:    half_period = 16'd33784;
            5'd8:    half_period = 16'd31888;
            5'd9:    half_period = 16'd30098;
            5'd10:   half_period = 16'd28409;
            5'd11:   half_period = 16'd26815;
            5'd12:   half_period = 16'd25310;
            5'd13:   half_period = 16'd23889;
            5'd14:   half_period = 16'd22549;
            5'd15:   half_period = 16'd21283;
            5'd16:   half_period = 16'd20088;
            5'd17:   half_period = 16'd18961;
            5'd18:   half_period = 16'd17897;
            5'd19:   half_period = 16'd16892;
            5'd20:   half_period = 16'd15944;
            5'd21:   half_period = 16'd15049;
            5'd22:   half_period = 16'd14205;
            5'd23:   half_period = 16'd13407;
            5'd24:   half_period = 16'd12655;
            default: half_period = 16'd0;
        endcase
    endfunction

    function automatic logic is_tone(input logic [PITCH_W-1:0] p);
        is_tone = (p != PITCH_REST) && (p <= PITCH_LAST);
    endfunction

    // C major scale, eighth notes, then end marker
    function automatic logic [8*ROM_DEPTH-1:0] demo_song();
        logic [8*ROM_DEPTH-1:0] s;
        s = '0;
        s[8*0 +: 8] = {P_C4, 3'd1};
        s[8*1 +: 8] = {P_D4, 3'd1};
        s[8*2 +: 8] = {P_E4, 3'd1};
        s[8*3 +: 8] = {P_F4, 3'd1};
        s[8*4 +: 8] = {P_G4, 3'd1};
        s[8*5 +: 8] = {P_A4, 3'd1};
        s[8*6 +: 8] = {P_B4, 3'd1};
        s[8*7 +: 8] = {P_C5, 3'd3};
        s[8*8 +: 8] = {PITCH_END, 3'd0};
        return s;
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Song ROM, 64 x {pitch[4:0], len[2:0]}, registered read.
// Ports: clk, rst_n, addr[5:0] in; data[7:0] out (1-cycle latency).
module melody_rom
    import sound_pkg::*;
#(
    parameter logic [8*ROM_DEPTH-1:0] SONG = demo_song()
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] addr,
    output logic [7:0]       data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            data <= SONG[{addr, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/melody_player.sv
// Plays a ROM song as a square wave, with inter-note gaps.
// Ports: CLK25M, RSTN, EN, START, STOP, LOOP in;
//        SPEAKER0, SPEAKER1, BUSY, NOTE_IDX[5:0] out.
module melody_player
    import sound_pkg::*;
#(
    parameter int TICK_DIV  = 1_562_500,
    parameter int GAP_CYC   = 250_000,
    // nonzero replaces every tone's half-period
    parameter int TEST_HALF = 0,
    parameter logic [8*ROM_DEPTH-1:0] SONG = demo_song()
) (
    input  logic             CLK25M,
    input  logic             RSTN,
    input  logic             EN,
    input  logic             START,
    input  logic             STOP,
    input  logic             LOOP,
    output logic             SPEAKER0,
    output logic             SPEAKER1,
    output logic             BUSY,
    output logic [IDX_W-1:0] NOTE_IDX
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    state_t              state;
    logic [7:0]          rom_q;
    logic [IDX_W-1:0]    idx_nxt;
    logic [PITCH_W-1:0]  pitch;
    logic [LEN_W-1:0]    len;
    logic [HALF_W-1:0]   half;
    logic                tone_on;
    logic                abort;
    logic                tick_last;
    logic                gap_last;
    logic [TW-1:0]       tick_cnt;
    logic [GW-1:0]       gap_cnt;
    logic [HALF_W-1:0]   tone_cnt;
    logic [LEN_W:0]      dur;

    assign pitch     = rom_q[7:3];
    assign len       = rom_q[2:0];
    assign tone_on   = is_tone(pitch);
    assign half      = (TEST_HALF != 0) ? HALF_W'(TEST_HALF)
                                        : half_period(pitch);
    assign abort     = (state != ST_IDLE) && (STOP || !EN);
    assign tick_last = tick_cnt == TW'(TICK_DIV - 1);
    assign gap_last  = gap_cnt == GW'(GAP_CYC - 1);
    assign BUSY      = state != ST_IDLE;

    // The ROM is addressed with the next index so the entry is
    // already valid during the single LOAD cycle.
    always_comb begin
        idx_nxt = NOTE_IDX;
        if (abort) begin
            idx_nxt = '0;
        end else begin
            unique case (state)
                ST_IDLE: idx_nxt = '0;
                ST_LOAD: if (pitch == PITCH_END) idx_nxt = '0;
                ST_PLAY: idx_nxt = NOTE_IDX;
                ST_GAP:  if (gap_last) idx_nxt = NOTE_IDX + 6'd1;
            endcase
        end
    end

    melody_rom #(
        .SONG (SONG)
    ) u_rom (
        .clk   (CLK25M),
        .rst_n (RSTN),
        .addr  (idx_nxt),
        .data  (rom_q)
    );

    always_ff @(posedge CLK25M or negedge RSTN) begin
        if (!RSTN) begin
            state    <= ST_IDLE;
            NOTE_IDX <= '0;
            SPEAKER0 <= 1'b0;
            SPEAKER1 <= 1'b0;
            tick_cnt <= '0;
            gap_cnt  <= '0;
            tone_cnt <= '0;
            dur      <= '0;
        end else begin
            NOTE_IDX <= idx_nxt;
            if (abort) begin
                state    <= ST_IDLE;
                SPEAKER0 <= 1'b0;
                SPEAKER1 <= 1'b0;
                tick_cnt <= '0;
                gap_cnt  <= '0;
                tone_cnt <= '0;
                dur      <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        SPEAKER0 <= 1'b0;
                        SPEAKER1 <= 1'b0;
                        if (START && EN && !STOP) state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        tick_cnt <= '0;
                        tone_cnt <= '0;
                        gap_cnt  <= '0;
                        dur      <= {1'b0, len} + 4'd1;
                        if (pitch == PITCH_END) begin
                            state <= LOOP ? ST_LOAD : ST_IDLE;
                        end else begin
                            state    <= ST_PLAY;
                            SPEAKER0 <= 1'b0;
                            SPEAKER1 <= tone_on;
                        end
                    end
                    ST_PLAY: begin
                        if (tick_last) begin
                            tick_cnt <= '0;
                            dur      <= dur - 4'd1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                        if (tick_last && dur == 4'd1) begin
                            state    <= ST_GAP;
                            SPEAKER0 <= 1'b0;
                            SPEAKER1 <= 1'b0;
                            tone_cnt <= '0;
                        end else if (tone_on) begin
                            if (tone_cnt == half - 16'd1) begin
                                tone_cnt <= '0;
                                SPEAKER0 <= ~SPEAKER0;
                                SPEAKER1 <= SPEAKER0;
                            end else begin
                                tone_cnt <= tone_cnt + 16'd1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_last) begin
                            gap_cnt <= '0;
                            state   <= ST_LOAD;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_player.sv
// Bench: three players with different songs share one stimulus;
// a timeline model predicts every output each cycle.
module tb_melody_player;

    localparam int TD = 16;
    localparam int GP = 4;
    localparam int HF = 3;
    localparam int N  = 3;

    logic clk = 1'b0;
    logic rstn, en, start, stop, loop;
    logic       spk0 [N];
    logic       spk1 [N];
    logic       busy [N];
    logic [5:0] nidx [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // 0: A4 two ticks then end; 1: one-tick rest then end;
    // 2: 64 playable entries, no end marker
    function automatic logic [511:0] song(int k);
        logic [511:0] s;
        s = '0;
        if (k == 0) begin
            s[7:0]  = {5'd10, 3'd1};
            s[15:8] = {5'd31, 3'd0};
        end else if (k == 1) begin
            s[7:0]  = 8'd0;
            s[15:8] = {5'd31, 3'd0};
        end else begin
            for (int i = 0; i < 64; i++)
                s[8*i +: 8] = {5'(i % 25), 3'(i % 2)};
        end
        return s;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        melody_player #(
            .TICK_DIV  (TD),
            .GAP_CYC   (GP),
            .TEST_HALF (HF),
            .SONG      (song(g))
        ) u_dut (
            .CLK25M   (clk),
            .RSTN     (rstn),
            .EN       (en),
            .START    (start),
            .STOP     (stop),
            .LOOP     (loop),
            .SPEAKER0 (spk0[g]),
            .SPEAKER1 (spk1[g]),
            .BUSY     (busy[g]),
            .NOTE_IDX (nidx[g])
        );
    end

    // model: phase (0 idle, 1 load, 2 play, 3 gap),
    // cycles elapsed in phase, note index
    logic [511:0] sg [N];
    int ph [N];
    int tt [N];
    int mi [N];

    initial begin
        for (int k = 0; k < N; k++) begin
            sg[k] = song(k);
            ph[k] = 0;
            tt[k] = 0;
            mi[k] = 0;
        end
        forever begin
            @(posedge clk or negedge rstn);
            for (int k = 0; k < N; k++) begin
                logic [7:0] e;
                e = sg[k][8*mi[k] +: 8];
                if (!rstn) begin
                    ph[k] = 0; tt[k] = 0; mi[k] = 0;
                end else if (ph[k] == 0) begin
                    if (start && en && !stop) begin
                        ph[k] = 1; mi[k] = 0;
                    end
                end else if (stop || !en) begin
                    ph[k] = 0; mi[k] = 0;
                end else if (ph[k] == 1) begin
                    if (e[7:3] == 5'd31) begin
                        if (!loop) ph[k] = 0;
                        mi[k] = 0;
                    end else begin
                        ph[k] = 2; tt[k] = 0;
                    end
                end else if (ph[k] == 2) begin
                    tt[k]++;
                    if (tt[k] == (int'(e[2:0]) + 1) * TD) begin
                        ph[k] = 3; tt[k] = 0;
                    end
                end else begin
                    tt[k]++;
                    if (tt[k] == GP) begin
                        ph[k] = 1; mi[k] = (mi[k] + 1) % 64;
                    end
                end
            end
        end
    end

    task automatic chk(string nm, logic [15:0] act, logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            if (bad < 30)
                $display("FAIL %s got=%0d want=%0d t=%0t",
                         nm, act, want, $time);
        end
    endtask

    int  prev2 = 0;
    bit  wrap_seen = 0;

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                logic [7:0] e;
                logic snd, s0, s1;
                e   = sg[k][8*mi[k] +: 8];
                snd = (ph[k] == 2) && e[7:3] >= 5'd1 && e[7:3] <= 5'd24;
                s0  = snd && ((tt[k] / HF) % 2 == 1);
                s1  = snd && !s0;
                chk($sformatf("spk0[%0d]", k), 16'(spk0[k]), 16'(s0));
                chk($sformatf("spk1[%0d]", k), 16'(spk1[k]), 16'(s1));
                chk($sformatf("busy[%0d]", k), 16'(busy[k]),
                    16'(ph[k] != 0));
                chk($sformatf("idx[%0d]", k), 16'(nidx[k]), 16'(mi[k]));
            end
            if (prev2 == 63 && nidx[2] == 6'd0 && busy[2])
                wrap_seen = 1;
            prev2 = int'(nidx[2]);
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int u1_idle = 0;
    int waited;

    initial begin
        rstn = 0; en = 1; start = 0; stop = 0; loop = 0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk("rst_spk0", 16'(spk0[k]), 16'd0);
            chk("rst_busy", 16'(busy[k]), 16'd0);
            chk("rst_idx", 16'(nidx[k]), 16'd0);
        end
        step(3);
        rstn = 1;
        step(2);

        start = 1; stop = 1;
        step(3);
        start = 0; stop = 0;
        step(1);
        chk("startstop_idle", 16'(busy[0]), 16'd0);

        start = 1;
        step(1);
        start = 0;
        chk("load_busy", 16'(busy[0]), 16'd1);
        step(1);
        chk("play_entry_spk0", 16'(spk0[0]), 16'd0);
        chk("play_entry_spk1", 16'(spk1[0]), 16'd1);
        step(3);
        chk("toggle1_spk0", 16'(spk0[0]), 16'd1);
        chk("toggle1_spk1", 16'(spk1[0]), 16'd0);
        step(3);
        chk("toggle2_spk0", 16'(spk0[0]), 16'd0);
        step(26);
        chk("gap_spk1", 16'(spk1[0]), 16'd0);
        chk("gap_busy", 16'(busy[0]), 16'd1);
        step(4);
        chk("next_idx", 16'(nidx[0]), 16'd1);
        step(1);
        chk("end_busy", 16'(busy[0]), 16'd0);
        chk("end_idx", 16'(nidx[0]), 16'd0);
        chk("u2_busy", 16'(busy[2]), 16'd1);

        loop = 1;
        start = 1;
        step(1);
        start = 0;
        chk("busy_start_idx", 16'(nidx[2]), 16'd1);
        for (int c = 0; c < 2200; c++) begin
            step(1);
            if (!busy[1]) u1_idle++;
        end
        chk("loop_stays_busy", 16'(u1_idle), 16'd0);
        chk("idx_wrap", 16'(wrap_seen), 16'd1);

        waited = 0;
        while (ph[2] != 3 && waited < 200) begin
            step(1);
            waited++;
        end
        chk("gap_wait_timeout", 16'(waited < 200), 16'd1);
        stop = 1;
        step(1);
        stop = 0;
        for (int k = 0; k < N; k++) begin
            chk("stop_busy", 16'(busy[k]), 16'd0);
            chk("stop_idx", 16'(nidx[k]), 16'd0);
        end

        loop = 0;
        start = 1;
        step(1);
        start = 0;
        step(10);
        chk("pre_en_spk0", 16'(spk0[0]), 16'd1);
        en = 0;
        step(1);
        chk("en_spk0", 16'(spk0[0]), 16'd0);
        chk("en_spk1", 16'(spk1[0]), 16'd0);
        chk("en_busy", 16'(busy[0]), 16'd0);
        en = 1;
        step(2);

        start = 1;
        step(1);
        start = 0;
        step(4);
        chk("pre_rst_spk0", 16'(spk0[0]), 16'd1);
        rstn = 0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk("arst_spk0", 16'(spk0[k]), 16'd0);
            chk("arst_spk1", 16'(spk1[k]), 16'd0);
            chk("arst_busy", 16'(busy[k]), 16'd0);
            chk("arst_idx", 16'(nidx[k]), 16'd0);
        end
        step(2);
        rstn = 1;
        step(5);
        for (int k = 0; k < N; k++)
            chk("post_rst_idle", 16'(busy[k]), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
